// File: rtl/pulse_gen_pkg.sv
// Shared FSM encoding, default phase lengths and the phase-timer sizing helper for pulse_train_gen.
package pulse_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int unsigned DEF_CNT_WIDTH   = 8;
  localparam int unsigned DEF_HIGH_CYCLES = 16;
  localparam int unsigned DEF_LOW_CYCLES  = 4;

  // Bits needed to hold the longer of the two phase lengths.
  function automatic int unsigned timer_width(input int unsigned high_cycles,
                                              input int unsigned low_cycles);
    int unsigned span;
    span = (high_cycles > low_cycles) ? high_cycles : low_cycles;
    return $clog2(span + 1);
  endfunction

endpackage

// File: rtl/pulse_train_gen_if.sv
// Request/status bundle of pulse_train_gen; master drives requests, slave (the generator) drives status.
interface pulse_train_gen_if #(
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 i_start;
  logic [CNT_WIDTH-1:0] i_pulse_num;
  logic                 i_stop;
  logic                 o_cnt_clk;
  logic                 o_cnt_rst;
  logic                 o_busy;
  logic                 o_done;
  logic [CNT_WIDTH-1:0] o_sent;

  modport master (
    output i_start, i_pulse_num, i_stop,
    input  o_cnt_clk, o_cnt_rst, o_busy, o_done, o_sent
  );

  modport slave (
    input  i_start, i_pulse_num, i_stop,
    output o_cnt_clk, o_cnt_rst, o_busy, o_done, o_sent
  );
endinterface

// File: rtl/pulse_gen_timer.sv
// Loadable count-down phase timer; holds at zero (no wrap) and flags expiry while the count is zero.
module pulse_gen_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired_c
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Emits a train of fixed-width level pulses on o_cnt_clk with graceful stop support.
// Optional counter pre-clear phase (CLR state, o_cnt_rst) is built when PULSE_GEN_CLR_EN is defined.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int unsigned LOW_CYCLES  = DEF_LOW_CYCLES
) (
  input logic               i_clk,
  input logic               i_rst,
  pulse_train_gen_if.slave  bus
);

  localparam int unsigned TMR_W = timer_width(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOW_LOAD  = TMR_W'(LOW_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] sent_q, sent_d;
  logic                 stop_q, stop_d;
  logic                 cnt_clk_q, busy_q, done_q;
  logic                 tmr_load;
  logic [TMR_W-1:0]     tmr_val;
  logic                 tmr_expired_c;
`ifdef PULSE_GEN_CLR_EN
  logic                 clr_low_q, clr_low_d;
  logic                 cnt_rst_q;
`endif

  pulse_gen_timer #(.WIDTH(TMR_W)) u_timer (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .expired_c (tmr_expired_c)
  );

  // State, bookkeeping and registered outputs; outputs decode the upcoming state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      sent_q    <= '0;
      stop_q    <= 1'b0;
      cnt_clk_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PULSE_GEN_CLR_EN
      clr_low_q <= 1'b0;
      cnt_rst_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sent_q    <= sent_d;
      stop_q    <= stop_d;
      cnt_clk_q <= (state_d == ST_HIGH);
      busy_q    <= (state_d inside {ST_CLR, ST_HIGH, ST_LOW});
      done_q    <= (state_d == ST_DONE);
`ifdef PULSE_GEN_CLR_EN
      clr_low_q <= clr_low_d;
      cnt_rst_q <= (state_d == ST_CLR) && !clr_low_d;
`endif
    end
  end

  // Next-state, timer reload and sticky-stop logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sent_d   = sent_q;
    stop_d   = stop_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef PULSE_GEN_CLR_EN
    clr_low_d = clr_low_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          count_d = bus.i_pulse_num;
          sent_d  = '0;
          stop_d  = bus.i_stop;
          if (bus.i_pulse_num == '0) begin
            state_d = ST_DONE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = HIGH_LOAD;
`ifdef PULSE_GEN_CLR_EN
            state_d   = ST_CLR;
            clr_low_d = 1'b0;
`else
            state_d   = ST_HIGH;
`endif
          end
        end
      end
`ifdef PULSE_GEN_CLR_EN
      ST_CLR: begin
        if (bus.i_stop) stop_d = 1'b1;
        if (tmr_expired_c) begin
          tmr_load = 1'b1;
          if (!clr_low_q) begin
            clr_low_d = 1'b1;
            tmr_val   = LOW_LOAD;
          end else begin
            clr_low_d = 1'b0;
            state_d   = ST_HIGH;
            tmr_val   = HIGH_LOAD;
          end
        end
      end
`endif
      ST_HIGH: begin
        if (bus.i_stop) stop_d = 1'b1;
        if (tmr_expired_c) begin
          sent_d   = sent_q + 1'b1;
          state_d  = ST_LOW;
          tmr_load = 1'b1;
          tmr_val  = LOW_LOAD;
        end
      end
      ST_LOW: begin
        if (bus.i_stop) stop_d = 1'b1;
        // A stop arriving on the final low cycle still ends the train.
        if (tmr_expired_c) begin
          if ((sent_q < count_q) && !stop_d) begin
            state_d  = ST_HIGH;
            tmr_load = 1'b1;
            tmr_val  = HIGH_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_cnt_clk = cnt_clk_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_sent    = sent_q;
`ifdef PULSE_GEN_CLR_EN
  assign bus.o_cnt_rst = cnt_rst_q;
`else
  assign bus.o_cnt_rst = 1'b0;
`endif

endmodule
